reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
//  Write-side master for the 32x32 register file (which commits on negedge clk, reads combinationally).
//  Holds the MEM/WB pipeline register, selects ALU result vs load data, and drives regWrite/writeReg/writeData.
//  Keeps a per-register pending-write scoreboard: ID issues increment it, WB retires and squashes decrement it.
//  The hazard unit uses the busy vector to stall readers of in-flight registers.
// PARAMETERS
//  DW     32  data width of writeData / aluResult / readData
//  AW     5   register index width (2**AW registers)
//  CNTW   2   width of each pending-write counter (max 2**CNTW-1 in flight per register)
// PORTS
//  clk           in   1      pipeline clock; all state updates on posedge
//  rst           in   1      asynchronous reset, active-low
//  mem_valid     in   1      MEM stage presents a retiring instruction this cycle
//  mem_regWrite  in   1      instruction writes a register
//  mem_memToReg  in   1      1: write load data, 0: write ALU result
//  mem_writeReg  in   AW     destination register
//  mem_aluResult in   DW     ALU result
//  mem_readData  in   DW     data-memory load data
//  flush         in   1      kill the instruction being captured this cycle
//  iss_valid     in   1      ID issues an instruction that writes iss_reg
//  iss_reg       in   AW     issued destination register
//  cxl_valid     in   1      a squashed in-flight writer to cxl_reg is cancelled
//  cxl_reg       in   AW     cancelled destination register
//  regWrite      out  1      register-file write enable
//  writeReg      out  AW     register-file write address
//  writeData     out  DW     register-file write data
//  busy          out  2**AW  busy[i]=1 while register i has a pending write
//  sb_err        out  1      sticky: counter overflow or underflow detected
//  fwd_valid     out  1      forwarding tap valid (WB_FWD_EN only)
//  fwd_reg       out  AW     forwarding tap register (WB_FWD_EN only)
//  fwd_data      out  DW     forwarding tap data (WB_FWD_EN only)
// BEHAVIOUR
//  Reset (rst=0, async): wb_valid=0, all counters=0, sb_err=0.
//   Result: regWrite=0, writeReg=0, writeData=0, busy=0, fwd_*=0.
//   Assertion mid-cycle drops regWrite immediately, so no negedge write occurs.
//  Pipeline register, posedge:
//   flush=1: wb_valid<=0.
//   Otherwise: wb_valid<=mem_valid and all mem_* fields are captured.
//   When mem_valid=0, data fields hold their old values (bubble).
//  Latency: a MEM instruction at cycle N drives regWrite in cycle N+1.
//   The register file commits at the negedge of N+1.
//  regWrite = wb_valid & wb_regWrite & (wb_writeReg!=0); a write to r0 is never issued.
//  writeReg = wb_writeReg; writeData = wb_memToReg ? wb_readData : wb_aluResult.
//   Both are forced to 0 while regWrite=0.
//  Scoreboard: one CNTW-bit counter per register. On each posedge, cnt[r] += inc - dec:
//   inc = iss_valid & iss_reg==r.
//   dec = (regWrite & writeReg==r) + (cxl_valid & cxl_reg==r).
//   Issue, retire and cancel on the same register in one cycle are combined into a single net update.
//   Register 0 is never counted; iss/cxl with reg 0 are ignored. busy[0]=0 always.
//   Overflow (result > max): counter saturates at max and sb_err<=1.
//   Underflow (result < 0): counter clamps at 0 and sb_err<=1.
//   sb_err clears only on reset.
//  busy[r] = (cnt[r]!=0); registered, so it is valid from the cycle after the update.
// CONFIGURATION
//  WB_FWD_EN defined:
//   fwd_valid=regWrite, fwd_reg=writeReg, fwd_data=writeData (combinational copies).
//   Used for the WB->EX bypass before the negedge commit.
//  WB_FWD_EN undefined: fwd_valid, fwd_reg and fwd_data are tied to 0 and no bypass logic is built.
// TESTING
//  ALU write: mem_valid=1, reg=5, alu=0x7, memToReg=0
//   -> next cycle regWrite=1, writeReg=5, writeData=0x7; regfile[5]=7 after the negedge.
//  Load and r0: memToReg=1, readData=0xDEADBEEF, reg=3 -> writeData=0xDEADBEEF.
//   Same stimulus with reg=0 -> regWrite stays 0.
//  Flush: mem_valid=1 with flush=1 -> regWrite=0 next cycle; busy is unchanged by the kill.
//  Scoreboard: issue r2 twice -> busy[2]=1, cnt=2.
//   Retire r2 in the same cycle as a new issue of r2 -> cnt stays 2.
//   Two further retires -> busy[2]=0.
//  Errors: issue r4 four times with no retire -> cnt=3, sb_err=1.
//   Separately, cancel r6 at cnt=0 -> cnt=0, sb_err=1.
//  Reset mid-op: pull rst low while regWrite=1 -> regWrite=0 immediately, no regfile write, busy=0.

Source files
------------

// File: rtl/reg_writeback_if.sv
// Write-back bundle between the MEM/ID pipeline side and the register-file write master.
interface reg_writeback_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic               mem_valid;
    logic               mem_regWrite;
    logic               mem_memToReg;
    logic [AW-1:0]      mem_writeReg;
    logic [DW-1:0]      mem_aluResult;
    logic [DW-1:0]      mem_readData;
    logic               flush;
    logic               iss_valid;
    logic [AW-1:0]      iss_reg;
    logic               cxl_valid;
    logic [AW-1:0]      cxl_reg;
    logic               regWrite;
    logic [AW-1:0]      writeReg;
    logic [DW-1:0]      writeData;
    logic [2**AW-1:0]   busy;
    logic               sb_err;
    logic               fwd_valid;
    logic [AW-1:0]      fwd_reg;
    logic [DW-1:0]      fwd_data;

    modport master (
        output mem_valid, mem_regWrite, mem_memToReg, mem_writeReg, mem_aluResult,
        output mem_readData, flush, iss_valid, iss_reg, cxl_valid, cxl_reg,
        input  regWrite, writeReg, writeData, busy, sb_err, fwd_valid, fwd_reg, fwd_data
    );

    modport slave (
        input  mem_valid, mem_regWrite, mem_memToReg, mem_writeReg, mem_aluResult,
        input  mem_readData, flush, iss_valid, iss_reg, cxl_valid, cxl_reg,
        output regWrite, writeReg, writeData, busy, sb_err, fwd_valid, fwd_reg, fwd_data
    );
endinterface

// File: rtl/reg_writeback.sv
// MEM/WB pipeline register, write-back mux and per-register pending-write scoreboard.
// Optional WB->EX forwarding tap is built only when WB_FWD_EN is defined.
module reg_writeback #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 2
) (
    input logic            clk,
    input logic            rst,
    reg_writeback_if.slave bus
);
    localparam int unsigned NR = 2**AW;
    // Counter math is done with a +2 bias so a double decrement never wraps.
    localparam int unsigned SW = CNTW + 2;
    localparam logic [SW-1:0] Bias   = SW'(2);
    localparam logic [SW-1:0] CntMax = SW'((2**CNTW) - 1);

    logic            wb_valid_q;
    logic            wb_reg_write_q;
    logic            wb_mem_to_reg_q;
    logic [AW-1:0]   wb_write_reg_q;
    logic [DW-1:0]   wb_alu_q;
    logic [DW-1:0]   wb_read_q;

    logic [CNTW-1:0] cnt_q [NR];
    logic [CNTW-1:0] cnt_d [NR];
    logic            err_q, err_d;

    logic            reg_write;
    logic            inc, dec_w, dec_c;
    logic [SW-1:0]   net;

    // MEM/WB capture; flush kills validity, bubbles keep the old data fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_write_reg_q  <= '0;
            wb_alu_q        <= '0;
            wb_read_q       <= '0;
        end else if (bus.flush) begin
            wb_valid_q <= 1'b0;
        end else begin
            wb_valid_q <= bus.mem_valid;
            if (bus.mem_valid) begin
                wb_reg_write_q  <= bus.mem_regWrite;
                wb_mem_to_reg_q <= bus.mem_memToReg;
                wb_write_reg_q  <= bus.mem_writeReg;
                wb_alu_q        <= bus.mem_aluResult;
                wb_read_q       <= bus.mem_readData;
            end
        end
    end

    // Register-file write port; address and data are zeroed when not writing.
    always_comb begin
        reg_write     = wb_valid_q && wb_reg_write_q && (wb_write_reg_q != '0);
        bus.regWrite  = reg_write;
        bus.writeReg  = reg_write ? wb_write_reg_q : '0;
        bus.writeData = '0;
        if (reg_write) begin
            bus.writeData = wb_mem_to_reg_q ? wb_read_q : wb_alu_q;
        end
    end

    // Net scoreboard update per register with saturate/clamp and sticky error.
    always_comb begin
        err_d = err_q;
        inc   = 1'b0;
        dec_w = 1'b0;
        dec_c = 1'b0;
        net   = '0;
        for (int r = 0; r < NR; r++) begin
            inc   = bus.iss_valid && (bus.iss_reg == AW'(r));
            dec_w = reg_write && (wb_write_reg_q == AW'(r));
            dec_c = bus.cxl_valid && (bus.cxl_reg == AW'(r));
            net   = {2'b00, cnt_q[r]} + Bias + {{(SW-1){1'b0}}, inc}
                    - {{(SW-1){1'b0}}, dec_w} - {{(SW-1){1'b0}}, dec_c};
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (net < Bias) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else if (net > CntMax + Bias) begin
                cnt_d[r] = CNTW'(CntMax);
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNTW'(net - Bias);
            end
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NR; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NR; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    // Busy vector straight from the counter registers.
    always_comb begin
        bus.busy = '0;
        for (int r = 0; r < NR; r++) begin
            bus.busy[r] = (cnt_q[r] != '0);
        end
        bus.sb_err = err_q;
    end

`ifdef WB_FWD_EN
    assign bus.fwd_valid = bus.regWrite;
    assign bus.fwd_reg   = bus.writeReg;
    assign bus.fwd_data  = bus.writeData;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_reg   = '0;
    assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: stimulus pushes expected WB/scoreboard state,
// a monitor pops and compares one entry per cycle after the posedge.
`timescale 1ns/1ps
module tb_reg_writeback;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int NR   = 32;
    localparam int CMAX = 3;

    typedef struct {
        logic          we;
        logic [31:0]   wr;
        logic [31:0]   wd;
        logic [31:0]   busy;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    reg_writeback_if #(.DW(DW), .AW(AW)) bus ();

    reg_writeback #(.DW(DW), .AW(AW), .CNTW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    exp_t sb_q[$];

    // Reference state: pending counts, sticky error, write presented this cycle.
    int   cnt [NR];
    bit   m_err;
    exp_t cur;

    // Register file that commits on the falling edge.
    logic [31:0] rf [NR];
    always @(negedge clk) begin
        if (bus.regWrite) rf[bus.writeReg] <= bus.writeData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < NR; r++) cnt[r] = 0;
        m_err   = 1'b0;
        cur.we  = 1'b0;
        cur.wr  = '0;
        cur.wd  = '0;
        cur.busy = '0;
        cur.err = 1'b0;
    endtask

    task automatic drive_idle();
        bus.mem_valid     = 1'b0;
        bus.mem_regWrite  = 1'b0;
        bus.mem_memToReg  = 1'b0;
        bus.mem_writeReg  = '0;
        bus.mem_aluResult = '0;
        bus.mem_readData  = '0;
        bus.flush         = 1'b0;
        bus.iss_valid     = 1'b0;
        bus.iss_reg       = '0;
        bus.cxl_valid     = 1'b0;
        bus.cxl_reg       = '0;
    endtask

    // One clock of stimulus; expectation for after the next posedge is queued.
    task automatic cycle(input bit mv, input bit rw, input bit m2r, input int wr,
                         input logic [31:0] alu, input logic [31:0] rd, input bit fl,
                         input bit iv, input int ir, input bit cv, input int cr);
        exp_t nx;
        int   n;
        @(negedge clk);
        bus.mem_valid     = mv;
        bus.mem_regWrite  = rw;
        bus.mem_memToReg  = m2r;
        bus.mem_writeReg  = AW'(wr);
        bus.mem_aluResult = alu;
        bus.mem_readData  = rd;
        bus.flush         = fl;
        bus.iss_valid     = iv;
        bus.iss_reg       = AW'(ir);
        bus.cxl_valid     = cv;
        bus.cxl_reg       = AW'(cr);
        nx.we = !fl && mv && rw && (wr != 0);
        nx.wr = nx.we ? 32'(wr) : 32'd0;
        nx.wd = nx.we ? (m2r ? rd : alu) : 32'd0;
        for (int r = 1; r < NR; r++) begin
            n = cnt[r];
            if (iv && ir == r) n++;
            if (cur.we && cur.wr == 32'(r)) n--;
            if (cv && cr == r) n--;
            if (n > CMAX) begin n = CMAX; m_err = 1'b1; end
            if (n < 0)    begin n = 0;    m_err = 1'b1; end
            cnt[r] = n;
        end
        nx.busy = '0;
        for (int r = 0; r < NR; r++) nx.busy[r] = (cnt[r] != 0);
        nx.err = m_err;
        sb_q.push_back(nx);
        cur = nx;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic iss(input int r);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, r, 0, 0);
    endtask

    task automatic mem(input int r, input bit m2r, input logic [31:0] alu, input logic [31:0] rd);
        cycle(1, 1, m2r, r, alu, rd, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_regWrite", 32'(bus.regWrite), 32'd0);
        check("rst_writeReg", 32'(bus.writeReg), 32'd0);
        check("rst_writeData", bus.writeData, 32'd0);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_sb_err", 32'(bus.sb_err), 32'd0);
        check("rst_fwd", {31'd0, bus.fwd_valid} | 32'(bus.fwd_reg) | bus.fwd_data, 32'd0);
        clear_model();
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: one expected entry per cycle, sampled well after the posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (mon_en && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("regWrite", 32'(bus.regWrite), 32'(e.we));
                check("writeReg", 32'(bus.writeReg), e.wr);
                check("writeData", bus.writeData, e.wd);
                check("busy", bus.busy, e.busy);
                check("sb_err", 32'(bus.sb_err), 32'(e.err));
`ifdef WB_FWD_EN
                check("fwd_valid", 32'(bus.fwd_valid), 32'(e.we));
                check("fwd_reg", 32'(bus.fwd_reg), e.wr);
                check("fwd_data", bus.fwd_data, e.wd);
`else
                check("fwd_tied", {31'd0, bus.fwd_valid} | 32'(bus.fwd_reg) | bus.fwd_data,
                      32'd0);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NR; r++) rf[r] = '0;
        drive_idle();
        clear_model();
        do_reset();

        // ALU write to r5, committed at the following negedge.
        iss(5);
        mem(5, 0, 32'h7, 32'h55);
        idle();
        #1;
        check("rf5_commit", rf[5], 32'h7);

        // Load write to r3, then the same to r0 which must not write.
        iss(3);
        mem(3, 1, 32'h11, 32'hDEADBEEF);
        mem(0, 1, 32'h11, 32'hDEADBEEF);
        idle();
        // Bubble with stale regWrite fields must not write.
        cycle(0, 1, 0, 8, 32'h99, 32'h0, 0, 0, 0, 0, 0);
        idle();

        // Flush kills the write; pending count on r7 is untouched, then cancelled.
        iss(7);
        cycle(1, 1, 0, 7, 32'hABC, 32'h0, 1, 0, 0, 0, 0);
        idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        idle();

        // r2: two issues, retire coinciding with an issue, then two retires.
        iss(2);
        iss(2);
        mem(2, 0, 32'h20, 32'h0);
        cycle(1, 1, 0, 2, 32'h21, 32'h0, 0, 1, 2, 0, 0);
        mem(2, 1, 32'h0, 32'h22);
        idle();
        idle();

        // Overflow: four issues of r4.
        do_reset();
        iss(4); iss(4); iss(4); iss(4);
        idle();

        // Underflow: cancel r6 with nothing pending.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        idle();

        // Reset asserted while a write is being presented.
        do_reset();
        iss(9);
        mem(9, 0, 32'h12345678, 32'h0);
        @(posedge clk);
        #4;
        check("midrst_pre_we", 32'(bus.regWrite), 32'd1);
        mon_en = 1'b0;
        rst = 1'b0;
        #0.5;
        check("midrst_we", 32'(bus.regWrite), 32'd0);
        check("midrst_busy", bus.busy, 32'd0);
        @(negedge clk);
        #1;
        check("midrst_rf9", rf[9], 32'd0);

        // Randomized traffic over a small register window to force collisions.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), 1'($urandom),
                  int'($urandom_range(0, 7)), $urandom, $urandom, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)));
        end
        idle();
        idle();
        @(posedge clk);
        #4;
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
